byte_deserializer: RTL

//  Parametrised byte-stream deserializer: packs DATA_W-bit input beats into words of
//  1, 2 or 4 lanes, selected at run time by mode. Internal lane counter replaces external
//  sub-rate clocks. Valid/ready on both sides plus one output holding register.

---
 rtl/byte_deserializer.sv | 109 ++++++++++
 1 files changed

// File: rtl/byte_deserializer.sv
// byte_deserializer: packs DATA_W-bit input beats into 1/2/4-lane words selected
// at run time by mode, with valid/ready on both sides and one output holding register.
module byte_deserializer #(
  parameter int DATA_W    = 8,
  parameter int MAX_LANES = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enb,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W*MAX_LANES-1:0]   out_data,
  output logic [2:0]                    out_lanes,
  output logic                          mode_err
);

  localparam int WORD_W = DATA_W * MAX_LANES;

  logic [1:0]        r_mode_q;
  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_acc;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_data;
  logic [2:0]        r_out_lanes;
  logic              r_mode_err;

  logic [2:0]        w_n;
  logic [1:0]        w_nm1;
  logic              w_last;
  logic [1:0]        w_lane;
  logic              w_mode_chg;
  logic              w_accept;
  logic              w_pop;
  logic [WORD_W-1:0] w_word;

  // Decode active lane count from the registered mode
  always_comb begin
    w_n   = 3'd1;
    w_nm1 = 2'd0;
    case (r_mode_q)
      2'b01:   begin w_n = 3'd2; w_nm1 = 2'd1; end
      2'b10:   begin w_n = 3'd4; w_nm1 = 2'd3; end
      default: begin w_n = 3'd1; w_nm1 = 2'd0; end
    endcase
  end

  assign w_last     = (r_cnt == w_nm1);
  assign w_lane     = (LSB_FIRST != 0) ? r_cnt : (w_nm1 - r_cnt);
  assign w_mode_chg = (mode != r_mode_q);
  assign in_ready   = enb && !w_mode_chg && !(w_last && r_out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_pop      = r_out_valid && out_ready;

  // Accumulator with the current beat merged into its lane; inactive lanes zeroed
  always_comb begin
    w_word = '0;
    for (int unsigned l = 0; l < MAX_LANES; l++) begin
      if (l < 32'(w_n)) begin
        if (l == 32'(w_lane)) w_word[l*DATA_W +: DATA_W] = in_data;
        else                  w_word[l*DATA_W +: DATA_W] = r_acc[l*DATA_W +: DATA_W];
      end
    end
  end

  // Lane counter, accumulator, mode tracking and output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q    <= mode;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lanes <= 3'd1;
      r_mode_err  <= 1'b0;
    end else begin
      r_mode_err <= 1'b0;
      // Pop clears valid unless a completion on the same edge reloads it below
      if (w_pop) r_out_valid <= 1'b0;
      if (w_mode_chg) begin
        r_mode_q   <= mode;
        r_cnt      <= '0;
        r_acc      <= '0;
        r_mode_err <= (r_cnt != 2'd0);
      end else if (w_accept) begin
        if (w_last) begin
          r_out_data  <= w_word;
          r_out_lanes <= w_n;
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
          r_acc       <= '0;
        end else begin
          r_acc <= w_word;
          r_cnt <= r_cnt + 2'd1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_lanes = r_out_lanes;
  assign mode_err  = r_mode_err;

endmodule
